uart_rx_oversampled: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_sampler.sv | 77 +++++++
 rtl/uart_rx_oversampled.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding, parity mode constants and the 2-of-3 vote used by the
// oversampled UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchroniser, per-bit baud counter and 3-sample majority around mid-bit.
// bit_val is meaningful only while sample_valid is high.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 325
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    input  logic cnt_clr,
    input  logic cnt_run,
    output logic rx_s,
    output logic rx_s_d,
    output logic sample_valid,
    output logic bit_val,
    output logic bit_end
);

    localparam int          HALF     = CLKS_PER_BIT / 2;
    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_S0   = 16'(HALF - 1);
    localparam logic [15:0] CNT_S1   = 16'(HALF);
    localparam logic [15:0] CNT_DEC  = 16'(HALF + 1);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        edge_q, edge_d;
    logic [15:0] cnt_q, cnt_d;
    logic        samp0_q, samp0_d;
    logic        samp1_q, samp1_d;

    always_comb begin
        sync1_d = rx_in;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        samp0_d = samp0_q;
        samp1_d = samp1_q;

        if (cnt_clr || !cnt_run) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        // The third vote is the live synchronised line at the decision point.
        if (cnt_run && (cnt_q == CNT_S0)) samp0_d = sync2_q;
        if (cnt_run && (cnt_q == CNT_S1)) samp1_d = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            edge_q  <= 1'b1;
            cnt_q   <= '0;
            samp0_q <= 1'b1;
            samp1_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
            samp0_q <= samp0_d;
            samp1_q <= samp1_d;
        end
    end

    assign rx_s         = sync2_q;
    assign rx_s_d       = edge_q;
    assign sample_valid = cnt_run && (cnt_q == CNT_DEC);
    assign bit_val      = majority3(samp0_q, samp1_q, sync2_q);
    assign bit_end      = cnt_run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receive front end: start validation, data/parity/stop deserialisation
// and per-frame error flags, emitted at the final stop-bit decision.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 325,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 break_det,
    output logic                 busy
);

    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_rx_oversampled: CLKS_PER_BIT must be 8..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_oversampled: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
        $error("uart_rx_oversampled: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_oversampled: STOP_BITS must be 1 or 2");
    end

    logic rx_s, rx_s_d, sample_valid, bit_val, bit_end;
    logic cnt_clr, cnt_run;

    state_t               state_q, state_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 par_bit_q, par_bit_d;
    logic                 perr_w_q, perr_w_d;
    logic                 ferr_w_q, ferr_w_d;
    logic                 stop_low_q, stop_low_d;
    logic                 wait_high_q, wait_high_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 busy_q, busy_d;
    logic                 ferr_next, stop_low_next;

    assign cnt_run = (state_q != IDLE);
    assign cnt_clr = (state_q == IDLE) && rx_s_d && !rx_s;

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (in),
        .cnt_clr     (cnt_clr),
        .cnt_run     (cnt_run),
        .rx_s        (rx_s),
        .rx_s_d      (rx_s_d),
        .sample_valid(sample_valid),
        .bit_val     (bit_val),
        .bit_end     (bit_end)
    );

    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        stop_idx_d    = stop_idx_q;
        shift_d       = shift_q;
        par_acc_d     = par_acc_q;
        par_bit_d     = par_bit_q;
        perr_w_d      = perr_w_q;
        ferr_w_d      = ferr_w_q;
        stop_low_d    = stop_low_q;
        wait_high_d   = wait_high_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        perr_d        = perr_q;
        ferr_d        = ferr_q;
        brk_d         = brk_q;
        ferr_next     = ferr_w_q | !bit_val;
        stop_low_next = stop_low_q & !bit_val;

        case (state_q)
            IDLE: begin
                // After a break the line is still low; re-arm only once it idles high.
                if (wait_high_q) begin
                    if (rx_s) wait_high_d = 1'b0;
                end else if (rx_s_d && !rx_s) begin
                    state_d    = START;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    shift_d    = '0;
                    par_acc_d  = 1'b0;
                    par_bit_d  = 1'b0;
                    perr_w_d   = 1'b0;
                    ferr_w_d   = 1'b0;
                    stop_low_d = 1'b1;
                end
            end
            START: begin
                if (sample_valid && bit_val) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample_valid) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (bit_idx_q == 4'(i)) shift_d[i] = bit_val;
                    end
                    par_acc_d = par_acc_q ^ bit_val;
                end
                if (bit_end) begin
                    if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (sample_valid) begin
                    par_bit_d = bit_val;
                    perr_w_d  = (PARITY_MODE == PAR_ODD) ? !(par_acc_q ^ bit_val)
                                                          : (par_acc_q ^ bit_val);
                end
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (sample_valid) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        // Finish at mid stop bit so a back-to-back start edge is not missed.
                        state_d     = IDLE;
                        rx_valid_d  = 1'b1;
                        rx_data_d   = shift_q;
                        perr_d      = perr_w_q;
                        ferr_d      = ferr_next;
                        brk_d       = (shift_q == '0) && !par_bit_q && stop_low_next;
                        wait_high_d = (shift_q == '0) && !par_bit_q && stop_low_next;
                    end else begin
                        ferr_w_d   = ferr_next;
                        stop_low_d = stop_low_next;
                    end
                end
                if (bit_end) stop_idx_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            perr_w_q    <= 1'b0;
            ferr_w_q    <= 1'b0;
            stop_low_q  <= 1'b0;
            wait_high_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            par_acc_q   <= par_acc_d;
            par_bit_q   <= par_bit_d;
            perr_w_q    <= perr_w_d;
            ferr_w_q    <= ferr_w_d;
            stop_low_q  <= stop_low_d;
            wait_high_q <= wait_high_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = perr_q;
    assign framing_err = ferr_q;
    assign break_det   = brk_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench: a no-parity receiver and an even-parity receiver at 16 clk/bit.
module tb_uart_rx_oversampled;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line0 = 1'b1;
    logic       line2 = 1'b1;

    logic [7:0] rx_data0, rx_data2;
    logic       rx_valid0, rx_valid2;
    logic       perr0, perr2, ferr0, ferr2, brk0, brk2, busy0, busy2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n0 = 0;
    int n2 = 0;
    int t_hist0[64];
    logic [7:0] d_hist0[64];

    always #5 clk = ~clk;

    uart_rx_oversampled #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in(line0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .parity_err(perr0), .framing_err(ferr0), .break_det(brk0), .busy(busy0)
    );

    uart_rx_oversampled #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in(line2), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .parity_err(perr2), .framing_err(ferr2), .break_det(brk2), .busy(busy2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid0) begin
            if (n0 < 64) begin
                t_hist0[n0] <= cyc;
                d_hist0[n0] <= rx_data0;
            end
            n0 <= n0 + 1;
        end
        if (rx_valid2) n2 <= n2 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input bit sel2, input logic b);
        if (sel2) line2 = b;
        else line0 = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel2, input logic [7:0] d, input logic par,
                              input logic stop, output int t0);
        t0 = cyc;
        drive_bit(sel2, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel2, d[i]);
        if (sel2) drive_bit(sel2, par);
        drive_bit(sel2, stop);
    endtask

    typedef struct {
        bit         sel2;
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         hold_low;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int nb, ts, ta, tb2, tx;

        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 0,  8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 1'b1, 1'b1, 0,  8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h3C, 1'b0, 1'b1, 0,  8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h55, 1'b0, 1'b0, 0,  8'h55, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 48, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b1, 0,  8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b0, 0,  8'h00, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 8'h81, 1'b0, 1'b1, 0,  8'h81, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h07, 1'b0, 1'b1, 0,  8'h07, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h01, 1'b0, 1'b1, 0,  8'h01, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset rx_data", 32'(rx_data0), 32'h0);
        chk("reset rx_valid", 32'(rx_valid0), 32'h0);
        chk("reset flags", {29'h0, perr0, ferr0, brk0}, 32'h0);
        chk("reset busy", {30'h0, busy0, busy2}, 32'h0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            nb = vecs[i].sel2 ? n2 : n0;
            send_frame(vecs[i].sel2, vecs[i].data, vecs[i].par, vecs[i].stop, ts);
            repeat (vecs[i].hold_low) @(negedge clk);
            line0 = 1'b1;
            line2 = 1'b1;
            repeat (40) @(negedge clk);
            if (vecs[i].sel2) begin
                chk($sformatf("v%0d pulses", i), 32'(n2 - nb), 32'd1);
                chk($sformatf("v%0d data", i), 32'(rx_data2), 32'(vecs[i].exp_data));
                chk($sformatf("v%0d parity_err", i), 32'(perr2), 32'(vecs[i].exp_perr));
                chk($sformatf("v%0d framing_err", i), 32'(ferr2), 32'(vecs[i].exp_ferr));
                chk($sformatf("v%0d break_det", i), 32'(brk2), 32'(vecs[i].exp_brk));
                chk($sformatf("v%0d busy", i), 32'(busy2), 32'd0);
            end else begin
                chk($sformatf("v%0d pulses", i), 32'(n0 - nb), 32'd1);
                chk($sformatf("v%0d data", i), 32'(rx_data0), 32'(vecs[i].exp_data));
                chk($sformatf("v%0d parity_err", i), 32'(perr0), 32'(vecs[i].exp_perr));
                chk($sformatf("v%0d framing_err", i), 32'(ferr0), 32'(vecs[i].exp_ferr));
                chk($sformatf("v%0d break_det", i), 32'(brk0), 32'(vecs[i].exp_brk));
                chk($sformatf("v%0d busy", i), 32'(busy0), 32'd0);
            end
        end

        // Five-cycle low glitch must be rejected as a false start
        nb = n0;
        line0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch busy high", 32'(busy0), 32'd1);
        line0 = 1'b1;
        repeat (15) @(negedge clk);
        chk("glitch busy low", 32'(busy0), 32'd0);
        repeat (30) @(negedge clk);
        chk("glitch no pulse", 32'(n0 - nb), 32'd0);

        // Back-to-back frames, next start immediately after a 1-bit stop
        nb = n0;
        send_frame(1'b0, 8'h01, 1'b0, 1'b1, ta);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b1, tb2);
        repeat (40) @(negedge clk);
        chk("b2b pulses", 32'(n0 - nb), 32'd2);
        chk("b2b first data", 32'(d_hist0[nb]), 32'h01);
        chk("b2b second data", 32'(d_hist0[nb+1]), 32'hFF);
        chk("b2b spacing", 32'(t_hist0[nb+1] - t_hist0[nb]), 32'd160);
        chk("latency window", 32'((t_hist0[nb] - ta >= 156) && (t_hist0[nb] - ta <= 158)), 32'd1);

        // Reset during data bit 4 discards the partial frame
        nb = n0;
        fork
            send_frame(1'b0, 8'h81, 1'b0, 1'b1, tx);
            begin
                repeat (84) @(negedge clk);
                rst_n = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        chk("midreset rx_data", 32'(rx_data0), 32'h0);
        chk("midreset rx_valid", 32'(rx_valid0), 32'h0);
        chk("midreset flags", {29'h0, perr0, ferr0, brk0}, 32'h0);
        chk("midreset busy", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(1'b0, 8'h42, 1'b0, 1'b1, tx);
        repeat (40) @(negedge clk);
        chk("postreset pulses", 32'(n0 - nb), 32'd1);
        chk("postreset data", 32'(rx_data0), 32'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
